cache_miss_controller: RTL and testbench

CACHE_MISS_CONTROLLER -- requirements
Module: cache_miss_controller

---
 rtl/cache_miss_controller_if.sv | 32 +++
 rtl/cache_miss_controller.sv | 115 +++++++++++
 tb/tb_cache_miss_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_controller_if.sv
// Bundles the CPU, cache and data-memory handshake signals of the cache miss controller.
// The master drives the requests and status inputs; the slave (the controller) drives the rest.
interface cache_miss_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cpu_read;
  logic             cpu_write;
  logic             hit;
  logic             dirty;
  logic             ram_ready;
  logic             stall;
  logic             ram_read;
  logic             ram_write;
  logic             cache_fill;
  logic             cache_update;
  logic [2:0]       state;
  logic             err;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output cpu_read, cpu_write, hit, dirty, ram_ready,
    input  stall, ram_read, ram_write, cache_fill, cache_update,
    input  state, err, hit_cnt, miss_cnt
  );

  modport slave (
    input  cpu_read, cpu_write, hit, dirty, ram_ready,
    output stall, ram_read, ram_write, cache_fill, cache_update,
    output state, err, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_miss_controller.sv
// Blocking-cache miss controller: writes back dirty victims, refills the line, fills the cache,
// then lets the held CPU access retry. Tracks hits/misses and traps on RAM timeouts.
module cache_miss_controller #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input logic                    clk,
  input logic                    reset,
  cache_miss_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITEBACK = 3'd1,
    REFILL    = 3'd2,
    FILL      = 3'd3,
    ERROR     = 3'd4
  } state_e;

  localparam int unsigned    WAIT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_L = WAIT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retry_q, retry_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic req;
  logic is_write;
  logic stall, ram_read, ram_write, cache_fill, cache_update;
  logic [WAIT_W-1:0] wait_inc;

  assign req      = bus.cpu_read | bus.cpu_write;
  assign is_write = bus.cpu_write;
  assign wait_inc = wait_q + WAIT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    retry_d      = retry_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    stall        = 1'b0;
    ram_read     = 1'b0;
    ram_write    = 1'b0;
    cache_fill   = 1'b0;
    cache_update = 1'b0;

    case (state_q)
      IDLE: begin
        // The retry flag only survives the first IDLE cycle after a fill.
        retry_d = 1'b0;
        if (req && bus.hit) begin
          cache_update = is_write;
          if (!retry_q && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else if (req) begin
          stall   = 1'b1;
          wait_d  = '0;
          state_d = bus.dirty ? WRITEBACK : REFILL;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      WRITEBACK, REFILL: begin
        stall     = 1'b1;
        ram_write = (state_q == WRITEBACK);
        ram_read  = (state_q == REFILL);
        if (bus.ram_ready) begin
          wait_d  = '0;
          state_d = (state_q == WRITEBACK) ? REFILL : FILL;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_L) state_d = ERROR;
        end
      end
      FILL: begin
        stall      = 1'b1;
        cache_fill = 1'b1;
        retry_d    = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        stall   = 1'b1;
        state_d = ERROR;
      end
    endcase
  end

  assign bus.stall        = stall;
  assign bus.ram_read     = ram_read;
  assign bus.ram_write    = ram_write;
  assign bus.cache_fill   = cache_fill;
  assign bus.cache_update = cache_update;
  assign bus.state        = state_q;
  assign bus.err          = (state_q == ERROR);
  assign bus.hit_cnt      = hit_cnt_q;
  assign bus.miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Self-checking bench for cache_miss_controller: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a cycle-level reference model.
module tb_cache_miss_controller;

  localparam int TMO  = 15;
  localparam int HMAX = 65535;

  logic clk;
  logic reset;

  cache_miss_controller_if #(.CNT_W(16)) bus ();
  cache_miss_controller_if #(.CNT_W(4))  bus4 ();

  cache_miss_controller #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cache_miss_controller #(.TIMEOUT(15), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: spec state numbers, wait count, retry flag, counters
  int m_st, m_wait, m_hits, m_misses;
  bit m_retry;
  bit cur_r, cur_w, cur_h, cur_d, cur_rdy;

  typedef struct packed {
    logic       r, w, h, d, rdy;
    logic [2:0] st;
    logic       stall, rr, rw, fill, upd;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit w, input bit h, input bit d, input bit rdy);
    cur_r = r; cur_w = w; cur_h = h; cur_d = d; cur_rdy = rdy;
    bus.cpu_read  = r;
    bus.cpu_write = w;
    bus.hit       = h;
    bus.dirty     = d;
    bus.ram_ready = rdy;
  endtask

  task automatic check_model();
    bit req;
    bit e_stall, e_rr, e_rw, e_fill, e_upd, e_err;
    req = cur_r | cur_w;
    e_stall = 0; e_rr = 0; e_rw = 0; e_fill = 0; e_upd = 0; e_err = 0;
    case (m_st)
      0: begin e_stall = req & ~cur_h; e_upd = req & cur_h & cur_w; end
      1: begin e_stall = 1; e_rw = 1; end
      2: begin e_stall = 1; e_rr = 1; end
      3: begin e_stall = 1; e_fill = 1; end
      default: begin e_stall = 1; e_err = 1; end
    endcase
    chk("state", 32'(bus.state), 32'(m_st));
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("ram_read", 32'(bus.ram_read), 32'(e_rr));
    chk("ram_write", 32'(bus.ram_write), 32'(e_rw));
    chk("cache_fill", 32'(bus.cache_fill), 32'(e_fill));
    chk("cache_update", 32'(bus.cache_update), 32'(e_upd));
    chk("err", 32'(bus.err), 32'(e_err));
    chk("hit_cnt", 32'(bus.hit_cnt), 32'(m_hits));
    chk("miss_cnt", 32'(bus.miss_cnt), 32'(m_misses));
  endtask

  task automatic model_edge();
    bit req;
    req = cur_r | cur_w;
    case (m_st)
      0: begin
        if (req && cur_h && !m_retry && m_hits < HMAX) m_hits++;
        if (req && !cur_h) begin
          if (m_misses < HMAX) m_misses++;
          m_st   = cur_d ? 1 : 2;
          m_wait = 0;
        end
        m_retry = 0;
      end
      1, 2: begin
        if (cur_rdy) begin
          m_st   = m_st + 1;
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait >= TMO) m_st = 4;
        end
      end
      3: begin m_st = 0; m_retry = 1; end
      default: ;
    endcase
  endtask

  // drive inputs, then check at the falling edge
  task automatic step(input bit r, input bit w, input bit h, input bit d, input bit rdy);
    drive(r, w, h, d, rdy);
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // asynchronous reset between clock edges, checked before any edge arrives
  task automatic do_reset(input bit check_now);
    reset = 1'b0;
    #2;
    if (check_now) begin
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_ram_write", 32'(bus.ram_write), 0);
      chk("rst_ram_read", 32'(bus.ram_read), 0);
      chk("rst_hit_cnt", 32'(bus.hit_cnt), 0);
      chk("rst_miss_cnt", 32'(bus.miss_cnt), 0);
      chk("rst_err", 32'(bus.err), 0);
    end
    drive(0, 0, 0, 0, 0);
    m_st = 0; m_wait = 0; m_hits = 0; m_misses = 0; m_retry = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    bus4.cpu_read = 0; bus4.cpu_write = 0; bus4.hit = 0; bus4.dirty = 0; bus4.ram_ready = 0;
    m_st = 0; m_wait = 0; m_hits = 0; m_misses = 0; m_retry = 0;
    #3;
    chk("init_state", 32'(bus.state), 0);
    chk("init_ram_write", 32'(bus.ram_write), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    //               r  w  h  d  rdy st stall rr rw fill upd
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'd2,1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd3,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,3'd1,1'b1,1'b0,1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,3'd2,1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0,3'd3,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b1,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'd2,1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,1'b1,1'b0,1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0};

    for (int unsigned i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].h, tbl[i].d, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_stall", i), 32'(bus.stall), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d_ram_read", i), 32'(bus.ram_read), 32'(tbl[i].rr));
      chk($sformatf("tbl%0d_ram_write", i), 32'(bus.ram_write), 32'(tbl[i].rw));
      chk($sformatf("tbl%0d_cache_fill", i), 32'(bus.cache_fill), 32'(tbl[i].fill));
      chk($sformatf("tbl%0d_cache_update", i), 32'(bus.cache_update), 32'(tbl[i].upd));
      check_model();
      advance();
    end
    chk("tbl_hit_cnt", 32'(bus.hit_cnt), 2);
    chk("tbl_miss_cnt", 32'(bus.miss_cnt), 3);

    // read hits from a fresh reset
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0);
      chk("rdhit_stall", 32'(bus.stall), 0);
      advance();
    end
    chk("rdhit_hit_cnt", 32'(bus.hit_cnt), 3);
    chk("rdhit_miss_cnt", 32'(bus.miss_cnt), 0);

    // timeout in REFILL, then ERROR is sticky and ignores ram_ready
    do_reset(1);
    step(1, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < TMO; i++) begin
      step(1, 0, 0, 0, 0);
      chk("tmo_refill_state", 32'(bus.state), 2);
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 1);
      chk("tmo_err_state", 32'(bus.state), 4);
      chk("tmo_err", 32'(bus.err), 1);
      chk("tmo_stall", 32'(bus.stall), 1);
      advance();
    end

    // abort a writeback with an asynchronous reset
    do_reset(1);
    step(0, 1, 0, 1, 0);
    advance();
    step(0, 1, 0, 1, 0);
    chk("wb_state", 32'(bus.state), 1);
    chk("wb_ram_write", 32'(bus.ram_write), 1);
    chk("wb_miss_cnt", 32'(bus.miss_cnt), 1);
    advance();
    do_reset(1);

    // randomized traffic with occasional slow memory phases
    begin
      int unsigned rdy_bias;
      rdy_bias = 2;
      for (int n = 0; n < 4000; n++) begin
        if (n % 200 == 0) rdy_bias = $urandom_range(0, 3) == 0 ? 8 : 2;
        if ((m_st == 4 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
          do_reset(1);
        end else begin
          step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, rdy_bias - 1) == 0);
          advance();
        end
      end
    end

    // 4-bit counters saturate
    do_reset(0);
    bus4.cpu_read = 1;
    bus4.hit      = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("sat_hit_cnt", 32'(bus4.hit_cnt), (i + 1 > 15) ? 15 : i + 1);
    end
    chk("sat_miss_cnt", 32'(bus4.miss_cnt), 0);
    chk("sat_stall", 32'(bus4.stall), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
